// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// Module   : mem_bus_ctrl
// Summary  : Takes byte or 16-bit requests from the CPU core and turns each one
//            into one or two RAM accesses with a set number of wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic                    req_word,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    output logic                    mem_enable,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    we_q;
    logic                    word_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2*DATA_WIDTH-1:0] wdata_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [2*DATA_WIDTH-1:0] rsp_rdata_q;
    logic                    mem_enable_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_address_q;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q;

    logic [ADDR_WIDTH-1:0]   w_addr_hi;

    // Natural truncation gives the required wrap from the top address to zero.
    assign w_addr_hi = addr_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            word_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_enable_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        we_q          <= req_we;
                        word_q        <= req_word;
                        addr_q        <= req_addr;
                        wdata_q       <= req_wdata;
                        rsp_rdata_q   <= '0;
                        req_ready_q   <= 1'b0;
                        mem_enable_q  <= 1'b1;
                        mem_we_q      <= req_we;
                        mem_address_q <= req_addr;
                        mem_wr_data_q <= req_wdata[DATA_WIDTH-1:0];
                        cnt_q         <= CNT_LOAD;
                        state_q       <= ACC_LO;
                    end
                end
                ACC_LO: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        if (!we_q) begin
                            rsp_rdata_q[DATA_WIDTH-1:0] <= mem_rd_data;
                        end
                        if (word_q) begin
                            // Enable stays high so the high byte follows with no gap.
                            mem_address_q <= w_addr_hi;
                            mem_wr_data_q <= wdata_q[2*DATA_WIDTH-1:DATA_WIDTH];
                            cnt_q         <= CNT_LOAD;
                            state_q       <= ACC_HI;
                        end else begin
                            mem_enable_q <= 1'b0;
                            mem_we_q     <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end
                    end
                end
                ACC_HI: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        if (!we_q) begin
                            rsp_rdata_q[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rd_data;
                        end
                        mem_enable_q <= 1'b0;
                        mem_we_q     <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_enable  = mem_enable_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_address_q;
    assign mem_wr_data = mem_wr_data_q;

endmodule

`default_nettype wire
